// File: rtl/tsl1401_scan_ctrl.sv
// Frame scan controller for the TSL1401CL 128-pixel line sensor: SI/CLK sequencing plus per-pixel ADC trigger.
// Define TSL1401_FLUSH_EN to precede the first frame after IDLE with a charge-flushing dummy scan.
//
// state  | meaning
// IDLE   | waiting for start, divider held at 0
// SI_SET | one tick with CLK low, then raise SI
// SI_CLK | edge 1 with SI high, then drop CLK/SI and trigger pixel 0
// SCAN   | CLK toggles per tick, edges 2..129, trigger on falls after 2..128
// GAP    | CLK/SI low for GAP_TICKS + 2*exposure ticks (GAP_TICKS only when flushing)
// DONE   | one tick, frame_done on entry, then next frame or IDLE
module tsl1401_scan_ctrl #(
   parameter int DIV_RATIO = 10,
   parameter int GAP_TICKS = 10,
   parameter int EXP_W     = 16
) (
   input  logic             clk_i,
   input  logic             reset_n_i,
   input  logic             start_i,
   input  logic             continuous_i,
   input  logic [EXP_W-1:0] exposure_i,
   output logic             busy_o,
   output logic             sensor_clk_o,
   output logic             sensor_si_o,
   output logic             adc_trig_o,
   output logic [6:0]       pix_idx_o,
   output logic             frame_done_o,
   output logic             req_drop_o
);

   localparam int DIV_W = (DIV_RATIO > 2) ? $clog2(DIV_RATIO) : 1;
   localparam int GAP_W = EXP_W + 2;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV_RATIO - 1);
   localparam logic [GAP_W-1:0] GAP_BASE = GAP_W'(GAP_TICKS);
`ifdef TSL1401_FLUSH_EN
   localparam logic FLUSH_EN = 1'b1;
`else
   localparam logic FLUSH_EN = 1'b0;
`endif

   typedef enum logic [2:0] {IDLE, SI_SET, SI_CLK, SCAN, GAP, DONE} state_t;

   state_t             state_q;
   logic [DIV_W-1:0]   div_q;
   logic [GAP_W-1:0]   gap_q;
   logic [EXP_W-1:0]   exp_q;
   logic [6:0]         pix_q;
   logic [6:0]         pix_idx_q;
   logic               sensor_clk_q;
   logic               sensor_si_q;
   logic               adc_trig_q;
   logic               frame_done_q;
   logic               req_drop_q;
   logic               pend_q;
   logic               flush_q;
   logic               tick;

   assign tick = (state_q != IDLE) && (div_q == DIV_LAST);

   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         state_q      <= IDLE;
         div_q        <= '0;
         gap_q        <= '0;
         exp_q        <= '0;
         pix_q        <= '0;
         pix_idx_q    <= '0;
         sensor_clk_q <= 1'b0;
         sensor_si_q  <= 1'b0;
         adc_trig_q   <= 1'b0;
         frame_done_q <= 1'b0;
         req_drop_q   <= 1'b0;
         pend_q       <= 1'b0;
         flush_q      <= 1'b0;
      end else begin
         adc_trig_q   <= 1'b0;
         frame_done_q <= 1'b0;
         req_drop_q   <= 1'b0;
         div_q        <= (state_q == IDLE || tick) ? '0 : div_q + 1'b1;

         if (state_q != IDLE && start_i) begin
            if (!pend_q) pend_q <= 1'b1;
            else         req_drop_q <= 1'b1;
         end

         case (state_q)
            IDLE: begin
               if (start_i) begin
                  state_q <= SI_SET;
                  exp_q   <= exposure_i;
                  flush_q <= FLUSH_EN;
               end
            end
            SI_SET: begin
               if (tick) begin
                  sensor_si_q <= 1'b1;
                  state_q     <= SI_CLK;
               end
            end
            SI_CLK: begin
               if (tick) begin
                  if (!sensor_clk_q) begin
                     sensor_clk_q <= 1'b1;
                  end else begin
                     sensor_clk_q <= 1'b0;
                     sensor_si_q  <= 1'b0;
                     pix_q        <= '0;
                     state_q      <= SCAN;
                     if (!flush_q) begin
                        adc_trig_q <= 1'b1;
                        pix_idx_q  <= '0;
                     end
                  end
               end
            end
            SCAN: begin
               if (tick) begin
                  sensor_clk_q <= !sensor_clk_q;
                  // pix_q == 127 on a falling tick means edge 129 just ended the scan
                  if (sensor_clk_q) begin
                     if (pix_q == 7'd127) begin
                        state_q <= GAP;
                        gap_q   <= flush_q ? GAP_BASE : GAP_BASE + {1'b0, exp_q, 1'b0};
                     end else begin
                        pix_q <= pix_q + 7'd1;
                        if (!flush_q) begin
                           adc_trig_q <= 1'b1;
                           pix_idx_q  <= pix_q + 7'd1;
                        end
                     end
                  end
               end
            end
            GAP: begin
               if (tick) begin
                  if (gap_q == GAP_W'(1)) begin
                     if (flush_q) begin
                        flush_q <= 1'b0;
                        state_q <= SI_SET;
                     end else begin
                        state_q      <= DONE;
                        frame_done_q <= 1'b1;
                     end
                  end else begin
                     gap_q <= gap_q - 1'b1;
                  end
               end
            end
            DONE: begin
               if (tick) begin
                  if (continuous_i || pend_q || start_i) begin
                     state_q    <= SI_SET;
                     exp_q      <= exposure_i;
                     // a start arriving as a pended one is consumed becomes the new pend
                     pend_q     <= pend_q && start_i;
                     req_drop_q <= 1'b0;
                  end else begin
                     state_q <= IDLE;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy_o       = (state_q != IDLE);
   assign sensor_clk_o = sensor_clk_q;
   assign sensor_si_o  = sensor_si_q;
   assign adc_trig_o   = adc_trig_q;
   assign pix_idx_o    = pix_idx_q;
   assign frame_done_o = frame_done_q;
   assign req_drop_o   = req_drop_q;

endmodule

// File: tb/tb_tsl1401_scan_ctrl.sv
// Directed bench for tsl1401_scan_ctrl: DIV_RATIO=4, GAP_TICKS=10, 12-bit exposure so the max-exposure frame stays short.
// Expected counts adapt to TSL1401_FLUSH_EN when the bench is built with it.
module tb_tsl1401_scan_ctrl;

   localparam int DIV = 4;
   localparam int G   = 10;
   localparam int EW  = 12;
`ifdef TSL1401_FLUSH_EN
   localparam int FL = 1;
`else
   localparam int FL = 0;
`endif
   // busy spans SI_SET(1) + SI_CLK(2) + SCAN(256) + GAP + DONE(1) ticks
   localparam int FRAME0 = (260 + G) * DIV;
   localparam int FLUSHC = FL * (259 + G) * DIV;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          start = 1'b0;
   logic          continuous = 1'b0;
   logic [EW-1:0] exposure = '0;
   logic          busy, sclk, si, trig, fdone, drop;
   logic [6:0]    pix;

   int checks = 0;
   int fails  = 0;

   tsl1401_scan_ctrl #(.DIV_RATIO(DIV), .GAP_TICKS(G), .EXP_W(EW)) dut (
      .clk_i(clk), .reset_n_i(reset_n), .start_i(start), .continuous_i(continuous),
      .exposure_i(exposure), .busy_o(busy), .sensor_clk_o(sclk), .sensor_si_o(si),
      .adc_trig_o(trig), .pix_idx_o(pix), .frame_done_o(fdone), .req_drop_o(drop)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   // event monitor sampled on the falling edge
   int si_rises = 0, clk_rises = 0, clk_rises_si = 0, trigs = 0, dones = 0, drops = 0;
   int pix_bad = 0, edge_bad = 0, si_len = 0, busy_len = 0, exp_pix = 0;
   int si_times[$];
   logic si_p = 1'b0, sclk_p = 1'b0, busy_p = 1'b0;

   always @(negedge clk) begin
      if (si && !si_p) begin
         si_rises++;
         si_times.push_back(cyc);
         exp_pix = 0;
         si_len = 0;
      end
      if (si) si_len++;
      if (sclk && !sclk_p) begin
         clk_rises++;
         if (si) clk_rises_si++;
      end
      if (trig) begin
         trigs++;
         if (pix !== exp_pix[6:0]) pix_bad++;
         if (!(sclk_p && !sclk)) edge_bad++;
         exp_pix++;
      end
      if (fdone) dones++;
      if (drop) drops++;
      if (busy && !busy_p) busy_len = 0;
      if (busy) busy_len++;
      si_p = si;
      sclk_p = sclk;
      busy_p = busy;
   end

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_idle(input int budget, output bit timed_out);
      timed_out = 1'b1;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (!busy) begin
            timed_out = 1'b0;
            break;
         end
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({busy, sclk, si, trig, fdone, drop, pix} !== 13'd0) begin
         fails++;
         $display("FAIL reset_outputs: got %b expected all zero", {busy, sclk, si, trig, fdone, drop, pix});
      end
      reset_n = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
         fails++;
         $display("FAIL reset_idle: busy=%b expected 0", busy);
      end
   endtask

   task automatic test_single_frame();
      int s0 = si_rises, c0 = clk_rises, cs0 = clk_rises_si, t0 = trigs, d0 = dones;
      int pb0 = pix_bad, eb0 = edge_bad;
      bit to;
      exposure = '0;
      pulse_start();
      wait_idle(5000, to);
      checks++;
      if (to) begin fails++; $display("FAIL single_timeout: busy=%b expected 0", busy); end
      checks++;
      if (si_rises - s0 != 1 + FL) begin fails++; $display("FAIL single_si_pulses: got %0d expected %0d", si_rises - s0, 1 + FL); end
      checks++;
      if (si_len != 2 * DIV) begin fails++; $display("FAIL single_si_width: got %0d expected %0d", si_len, 2 * DIV); end
      checks++;
      if (clk_rises_si - cs0 != 1 + FL) begin fails++; $display("FAIL single_si_straddle: got %0d expected %0d", clk_rises_si - cs0, 1 + FL); end
      checks++;
      if (clk_rises - c0 != 129 * (1 + FL)) begin fails++; $display("FAIL single_clk_edges: got %0d expected %0d", clk_rises - c0, 129 * (1 + FL)); end
      checks++;
      if (trigs - t0 != 128) begin fails++; $display("FAIL single_trigs: got %0d expected 128", trigs - t0); end
      checks++;
      if (pix_bad != pb0 || edge_bad != eb0) begin fails++; $display("FAIL single_pix_order: got %0d/%0d bad expected 0/0", pix_bad - pb0, edge_bad - eb0); end
      checks++;
      if (dones - d0 != 1) begin fails++; $display("FAIL single_frame_done: got %0d expected 1", dones - d0); end
      checks++;
      if (busy_len != FRAME0 + FLUSHC) begin fails++; $display("FAIL single_period: got %0d expected %0d", busy_len, FRAME0 + FLUSHC); end
      checks++;
      if (pix !== 7'd127) begin fails++; $display("FAIL single_pix_hold: got %0d expected 127", pix); end
   endtask

   task automatic test_continuous();
      int s0 = si_rises, d0 = dones, t0 = trigs, n;
      bit to;
      exposure = EW'(5);
      continuous = 1'b1;
      pulse_start();
      for (int i = 0; i < 10000 && si_rises - s0 < 3 + FL; i++) @(negedge clk);
      continuous = 1'b0;
      wait_idle(5000, to);
      n = si_times.size();
      checks++;
      if (to || si_rises - s0 != 3 + FL) begin fails++; $display("FAIL cont_frames_si: got %0d expected %0d", si_rises - s0, 3 + FL); end
      checks++;
      if (dones - d0 != 3) begin fails++; $display("FAIL cont_frame_done: got %0d expected 3", dones - d0); end
      checks++;
      if (n < 3 || si_times[n-1] - si_times[n-2] != (270 + G) * DIV) begin
         fails++; $display("FAIL cont_spacing_23: got %0d expected %0d", (n < 3) ? 0 : si_times[n-1] - si_times[n-2], (270 + G) * DIV);
      end
      checks++;
      if (n < 3 || si_times[n-2] - si_times[n-3] != (270 + G) * DIV) begin
         fails++; $display("FAIL cont_spacing_12: got %0d expected %0d", (n < 3) ? 0 : si_times[n-2] - si_times[n-3], (270 + G) * DIV);
      end
      checks++;
      if (trigs - t0 != 3 * 128) begin fails++; $display("FAIL cont_trigs: got %0d expected %0d", trigs - t0, 3 * 128); end
      // drop continuous during frame 2
      s0 = si_rises; d0 = dones;
      continuous = 1'b1;
      pulse_start();
      for (int i = 0; i < 10000 && si_rises - s0 < 2 + FL; i++) @(negedge clk);
      repeat (50) @(negedge clk);
      continuous = 1'b0;
      wait_idle(5000, to);
      checks++;
      if (to || dones - d0 != 2) begin fails++; $display("FAIL cont_stop_frames: got %0d expected 2", dones - d0); end
      exposure = '0;
   endtask

   task automatic test_back_to_back();
      int s0 = si_rises, d0 = dones, t0 = trigs, r0 = drops;
      bit to;
      pulse_start();
      repeat (100) @(negedge clk);
      pulse_start();
      repeat (2) @(negedge clk);
      checks++;
      if (drops != r0) begin fails++; $display("FAIL b2b_first_pend: got %0d drops expected 0", drops - r0); end
      repeat (10) @(negedge clk);
      pulse_start();
      wait_idle(8000, to);
      checks++;
      if (to) begin fails++; $display("FAIL b2b_timeout: busy=%b expected 0", busy); end
      checks++;
      if (drops - r0 != 1) begin fails++; $display("FAIL b2b_req_drop: got %0d expected 1", drops - r0); end
      checks++;
      if (dones - d0 != 2) begin fails++; $display("FAIL b2b_frames: got %0d expected 2", dones - d0); end
      checks++;
      if (trigs - t0 != 256 || si_rises - s0 != 2 + FL) begin
         fails++; $display("FAIL b2b_scans: got %0d trigs %0d si expected 256 trigs %0d si", trigs - t0, si_rises - s0, 2 + FL);
      end
   endtask

   task automatic test_reset_mid_frame();
      int d0 = dones, t0, pb0;
      bit found = 1'b0, to;
      pulse_start();
      for (int i = 0; i < 5000 && !found; i++) begin
         @(negedge clk);
         if (trig && pix == 7'd60) found = 1'b1;
      end
      checks++;
      if (!found) begin fails++; $display("FAIL midreset_reach_pix60: got none expected trigger at 60"); end
      reset_n = 1'b0;
      @(negedge clk);
      checks++;
      if ({sclk, si, trig, busy, pix} !== 11'd0) begin
         fails++; $display("FAIL midreset_outputs: got %b expected all zero", {sclk, si, trig, busy, pix});
      end
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      repeat (20) @(negedge clk);
      checks++;
      if (dones != d0 || busy !== 1'b0) begin fails++; $display("FAIL midreset_no_done: got %0d done busy=%b expected 0 done idle", dones - d0, busy); end
      t0 = trigs; pb0 = pix_bad;
      pulse_start();
      wait_idle(5000, to);
      checks++;
      if (to || trigs - t0 != 128 || pix_bad != pb0 || dones - d0 != 1) begin
         fails++; $display("FAIL midreset_clean_frame: got %0d trigs %0d bad %0d done expected 128/0/1", trigs - t0, pix_bad - pb0, dones - d0);
      end
   endtask

   task automatic test_max_exposure();
      int d0 = dones;
      bit to;
      exposure = '1;
      pulse_start();
      repeat (50) @(negedge clk);
      exposure = '0;
      wait_idle(40000, to);
      checks++;
      if (to || busy_len != (260 + G + 2 * ((1 << EW) - 1)) * DIV + FLUSHC) begin
         fails++; $display("FAIL maxexp_period: got %0d expected %0d", busy_len, (260 + G + 2 * ((1 << EW) - 1)) * DIV + FLUSHC);
      end
      checks++;
      if (dones - d0 != 1) begin fails++; $display("FAIL maxexp_frame_done: got %0d expected 1", dones - d0); end
      pulse_start();
      wait_idle(5000, to);
      checks++;
      if (to || busy_len != FRAME0 + FLUSHC) begin fails++; $display("FAIL maxexp_relatch: got %0d expected %0d", busy_len, FRAME0 + FLUSHC); end
   endtask

   initial begin
      test_reset();
      test_single_frame();
      test_continuous();
      test_back_to_back();
      test_reset_mid_frame();
      test_max_exposure();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
